sm4_sbox_inv_search: RTL and testbench
======================================

Name: sm4_sbox_inv_search

Overview:
Sequential inverse SM4 S-box. Given a substituted byte y, it finds x such that SM4 S-box(x) == y. It does this by iterating candidates through LANES instances of the team's existing forward S-box module (SM4, ports b/Sb). It sits beside the forward S-box as its inverse-direction counterpart, with valid/ready handshakes on both sides.

Parameters:
LANES, 1, number of candidates checked per cycle; legal values 1, 2, 4, 8, 16; one SM4 instance per lane.
ITER_W, $clog2(256/LANES)+1, width of the iteration counter and of out_iters.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request; high only in IDLE.
in_data  input  8  S-box output byte y to invert.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts the result.
out_data  output  8  preimage x.
out_iters  output  ITER_W  number of search cycles used, 1..256/LANES.
out_err  output  1  no preimage found; unreachable with a correct S-box.
busy  output  1  high in SEARCH or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_data = 0, out_iters = 0, out_err = 0, busy = 0.
  - Internal target and base registers are cleared.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready: target <= in_data, base <= 0, iter <= 0, state -> SEARCH.
- SEARCH:
  - in_ready = 0, busy = 1.
  - Lane k drives SM4.b = base + k.
  - match_k = (SM4.Sb == target).
  - At each edge: if any match_k, the lowest matching k wins. Then out_data <= base + k, out_iters <= iter + 1, out_err <= 0, out_valid <= 1, state -> DONE.
  - Otherwise base <= base + LANES and iter <= iter + 1.
  - If the last group (base == 256 - LANES) has no match: out_data <= 0, out_err <= 1, out_iters <= 256/LANES, out_valid <= 1, state -> DONE.
- DONE:
  - out_valid = 1; out_data, out_iters and out_err are stable.
  - On an edge with out_ready: out_valid <= 0, state -> IDLE.
  - in_ready stays 0 until the cycle after that handshake; there is no same-cycle accept of a new request.
- Latency: out_valid rises floor(x/LANES)+1 edges after the accept edge.
  - LANES=1: min 1, max 256.
  - LANES=16: max 16.
- Base arithmetic is 9-bit internally, so the wrap test (base + LANES > 255) is exact. Lane candidates are the low 8 bits.
- in_valid asserted outside IDLE is ignored; no queueing.
- in_data is sampled only at the accept edge. Later changes do not affect the search in progress.
- out_ready is ignored outside DONE.
- Reset asserted mid-SEARCH or in DONE aborts immediately to the reset values. There is no residual output.
- The S-box instances are purely combinational. All outputs of this block are registered, with no combinational path from in_* to out_*.

Decomposition:
- Shared package sm4_pkg:
  - state enum {IDLE, SEARCH, DONE};
  - constant SM4_SBOX_ENTRIES = 256;
  - legal-LANES check function.
- One natural sub-module, sm4_inv_lane: wraps one SM4 instance plus its candidate adder and the compare against target, and outputs match. It is instantiated LANES times through a generate loop.
- The priority select and FSM stay in the top module.

Test Plan:
- LANES=1, reset, then in_data=0xD6 -> out_data=0x00, out_iters=1, out_valid exactly 1 cycle after accept, out_err=0.
- LANES=1, in_data=0x48 -> out_data=0xFF, out_iters=256; busy high throughout; in_ready low until after the out handshake.
- LANES=1, in_data=0x2B -> out_data=0x10, out_iters=17. Hold out_ready=0 for 5 cycles -> outputs stable, then one handshake returns the block to IDLE with in_ready=1.
- Exhaustive sweep for LANES=1 and LANES=16, y = 0x00..0xFF:
  - check SM4(out_data) == y against sbox_ref;
  - LANES=16: out_iters = floor(x/16)+1 (e.g. y=0x48 -> 16);
  - out_err never set.
- Assert rst_n low at iter 40 of the search for y=0x48 -> all outputs return to reset values asynchronously. After release, a new request y=0x90 -> out_data=0x01.
- Toggle in_valid and in_data during SEARCH for y=0xE9 -> result still 0x02; the extra requests are neither accepted nor queued.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 inverse S-box search.
package sm4_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int SM4_SBOX_ENTRIES = 256;

   function automatic bit lanes_legal(input int l);
      return (l == 1) || (l == 2) || (l == 4) || (l == 8) || (l == 16);
   endfunction

endpackage

// File: rtl/sm4_sbox_inv_search_if.sv
// Request/response handshake bundle for the inverse S-box search.
interface sm4_sbox_inv_search_if #(
   parameter int ITER_W = 9
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic [ITER_W-1:0] out_iters;
   logic              out_err;
   logic              busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_iters, out_err, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_iters, out_err, busy
   );
endinterface

// File: rtl/SM4.sv
// Forward SM4 S-box, purely combinational table lookup.
module SM4 (
   input  logic [7:0] b,
   output logic [7:0] Sb
);
   // Byte 0 sits in the MSBs, so entry b starts at bit (255-b)*8 = {~b,3'b0}.
   localparam logic [2047:0] TBL = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   logic [10:0] off;
   assign off = {~b, 3'b000};
   assign Sb  = TBL[off +: 8];
endmodule

// File: rtl/sm4_inv_lane.sv
// One search lane: candidate = base + K, forward S-box, compare with target.
module sm4_inv_lane #(
   parameter int unsigned K = 0
) (
   input  logic [7:0] base_i,
   input  logic [7:0] target_i,
   output logic       match_o
);
   logic [7:0] cand;
   logic [7:0] sb;

   assign cand = base_i + 8'(K);

   SM4 u_sbox (
      .b  (cand),
      .Sb (sb)
   );

   assign match_o = (sb == target_i);
endmodule

// File: rtl/sm4_sbox_inv_search.sv
// Inverse SM4 S-box by brute-force search, LANES candidates per cycle.
module sm4_sbox_inv_search
   import sm4_pkg::*;
#(
   parameter int LANES  = 1,
   parameter int ITER_W = $clog2(256 / LANES) + 1
) (
   input logic                   clk,
   input logic                   rst_n,
   sm4_sbox_inv_search_if.slave  bus
);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("sm4_sbox_inv_search: LANES must be 1, 2, 4, 8 or 16");
   end

   localparam logic [8:0]        LAST_BASE = 9'(SM4_SBOX_ENTRIES - LANES);
   localparam logic [ITER_W-1:0] ITERS_MAX = ITER_W'(SM4_SBOX_ENTRIES / LANES);

   state_e            state_q, state_d;
   logic [7:0]        target_q, target_d;
   logic [8:0]        base_q, base_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [7:0]        data_q, data_d;
   logic [ITER_W-1:0] iters_q, iters_d;
   logic              err_q, err_d;

   logic [LANES-1:0]  match;
   logic              hit;
   logic [7:0]        sel_off;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sm4_inv_lane #(.K(k)) u_lane (
         .base_i   (base_q[7:0]),
         .target_i (target_q),
         .match_o  (match[k])
      );
   end

   // Descending scan so the lowest matching lane is the one left standing.
   always_comb begin
      hit     = 1'b0;
      sel_off = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (match[k]) begin
            hit     = 1'b1;
            sel_off = 8'(k);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      base_d   = base_q;
      iter_d   = iter_q;
      data_d   = data_q;
      iters_d  = iters_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               target_d = bus.in_data;
               base_d   = '0;
               iter_d   = '0;
               state_d  = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               data_d  = base_q[7:0] + sel_off;
               iters_d = iter_q + ITER_W'(1);
               err_d   = 1'b0;
               state_d = DONE;
            end else if (base_q == LAST_BASE) begin
               data_d  = '0;
               iters_d = ITERS_MAX;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               base_d = base_q + 9'(LANES);
               iter_d = iter_q + ITER_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
         base_q   <= '0;
         iter_q   <= '0;
         data_q   <= '0;
         iters_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         base_q   <= base_d;
         iter_q   <= iter_d;
         data_q   <= data_d;
         iters_q  <= iters_d;
         err_q    <= err_d;
      end
   end

   // Status decodes come straight off the state register.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = data_q;
   assign bus.out_iters = iters_q;
   assign bus.out_err   = err_q;

endmodule

// File: tb/tb_sm4_sbox_inv_search.sv
// Directed bench for the inverse S-box search, LANES=1 and LANES=16 instances.
module tb_sm4_sbox_inv_search;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sm4_sbox_inv_search_if #(.ITER_W(9)) if1 ();
   sm4_sbox_inv_search_if #(.ITER_W(5)) if16 ();

   sm4_sbox_inv_search #(.LANES(1), .ITER_W(9)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .bus (if1)
   );
   sm4_sbox_inv_search #(.LANES(16), .ITER_W(5)) u_dut16 (
      .clk (clk), .rst_n (rst_n), .bus (if16)
   );

   int errors = 0;
   int checks = 0;

   logic [2047:0] sbox_bits = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [7:0] sref(input logic [7:0] x);
      logic [10:0] off;
      off = {~x, 3'b000};
      return sbox_bits[off +: 8];
   endfunction

   function automatic int inv(input logic [7:0] y);
      for (int i = 0; i < 256; i++)
         if (sref(8'(i)) == y) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [7:0] y);
      if1.in_valid = 1'b1;
      if1.in_data  = y;
      tick();
      if1.in_valid = 1'b0;
   endtask

   task automatic ack1();
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
   endtask

   task automatic wait1(output int cyc);
      cyc = 0;
      while (if1.out_valid !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      if1.in_valid = 0; if1.in_data = 0; if1.out_ready = 0;
      if16.in_valid = 0; if16.in_data = 0; if16.out_ready = 0;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", if1.in_ready); end
      checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", if1.out_valid); end
      checks++; if (if1.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", if1.out_data); end
      checks++; if (if1.out_iters !== 9'd0) begin errors++; $display("FAIL reset_out_iters got=%0d want=0", if1.out_iters); end
      checks++; if (if1.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b want=0", if1.out_err); end
      checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", if1.busy); end
      checks++; if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0 || if16.busy !== 1'b0)
         begin errors++; $display("FAIL reset_l16 got rdy=%b vld=%b busy=%b want 1/0/0", if16.in_ready, if16.out_valid, if16.busy); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_first();
      int cyc;
      send1(8'hD6);
      checks++; if (if1.out_valid !== 1'b0 || if1.busy !== 1'b1 || if1.in_ready !== 1'b0)
         begin errors++; $display("FAIL first_accept got vld=%b busy=%b rdy=%b want 0/1/0", if1.out_valid, if1.busy, if1.in_ready); end
      wait1(cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL first_latency got=%0d want=1", cyc); end
      checks++; if (if1.out_data !== 8'h00) begin errors++; $display("FAIL first_data got=%h want=00", if1.out_data); end
      checks++; if (if1.out_iters !== 9'd1) begin errors++; $display("FAIL first_iters got=%0d want=1", if1.out_iters); end
      checks++; if (if1.out_err !== 1'b0) begin errors++; $display("FAIL first_err got=%b want=0", if1.out_err); end
      ack1();
      checks++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1 || if1.busy !== 1'b0)
         begin errors++; $display("FAIL first_ack got vld=%b rdy=%b busy=%b want 0/1/0", if1.out_valid, if1.in_ready, if1.busy); end
   endtask

   task automatic test_max();
      int cyc;
      int bad;
      send1(8'h48);
      cyc = 0; bad = 0;
      while (if1.out_valid !== 1'b1 && cyc < 300) begin
         if (if1.busy !== 1'b1 || if1.in_ready !== 1'b0) bad++;
         tick();
         cyc++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL max_busy_cycles got=%0d bad want=0", bad); end
      checks++; if (cyc !== 256) begin errors++; $display("FAIL max_latency got=%0d want=256", cyc); end
      checks++; if (if1.out_data !== 8'hFF) begin errors++; $display("FAIL max_data got=%h want=ff", if1.out_data); end
      checks++; if (if1.out_iters !== 9'd256) begin errors++; $display("FAIL max_iters got=%0d want=256", if1.out_iters); end
      checks++; if (if1.in_ready !== 1'b0 || if1.busy !== 1'b1)
         begin errors++; $display("FAIL max_done_rdy got rdy=%b busy=%b want 0/1", if1.in_ready, if1.busy); end
      ack1();
      checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL max_ack_rdy got=%b want=1", if1.in_ready); end
   endtask

   task automatic test_hold();
      int cyc;
      int bad;
      send1(8'h2B);
      wait1(cyc);
      checks++; if (if1.out_data !== 8'h10) begin errors++; $display("FAIL hold_data got=%h want=10", if1.out_data); end
      checks++; if (if1.out_iters !== 9'd17) begin errors++; $display("FAIL hold_iters got=%0d want=17", if1.out_iters); end
      bad = 0;
      repeat (5) begin
         tick();
         if (if1.out_valid !== 1'b1 || if1.out_data !== 8'h10 || if1.out_iters !== 9'd17 ||
             if1.out_err !== 1'b0 || if1.in_ready !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad); end
      ack1();
      checks++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0)
         begin errors++; $display("FAIL hold_ack got rdy=%b vld=%b want 1/0", if1.in_ready, if1.out_valid); end
   endtask

   task automatic test_sweep();
      for (int y = 0; y < 256; y++) begin
         int x;
         int c1;
         int c16;
         x = inv(8'(y));
         if1.in_valid = 1'b1;  if1.in_data = 8'(y);
         if16.in_valid = 1'b1; if16.in_data = 8'(y);
         tick();
         if1.in_valid = 1'b0; if16.in_valid = 1'b0;
         c1 = -1; c16 = -1;
         for (int c = 1; c <= 300 && (c1 < 0 || c16 < 0); c++) begin
            tick();
            if (c1 < 0 && if1.out_valid === 1'b1) c1 = c;
            if (c16 < 0 && if16.out_valid === 1'b1) c16 = c;
         end
         checks++; if (sref(if1.out_data) !== 8'(y)) begin errors++; $display("FAIL sweep1_sbox y=%h got x=%h want sbox(x)=y", y, if1.out_data); end
         checks++; if (if1.out_data !== 8'(x)) begin errors++; $display("FAIL sweep1_data y=%h got=%h want=%h", y, if1.out_data, x); end
         checks++; if (if1.out_iters !== 9'(x + 1) || c1 !== x + 1)
            begin errors++; $display("FAIL sweep1_iters y=%h got=%0d lat=%0d want=%0d", y, if1.out_iters, c1, x + 1); end
         checks++; if (if1.out_err !== 1'b0) begin errors++; $display("FAIL sweep1_err y=%h got=%b want=0", y, if1.out_err); end
         checks++; if (sref(if16.out_data) !== 8'(y)) begin errors++; $display("FAIL sweep16_sbox y=%h got x=%h want sbox(x)=y", y, if16.out_data); end
         checks++; if (if16.out_iters !== 5'(x / 16 + 1) || c16 !== x / 16 + 1)
            begin errors++; $display("FAIL sweep16_iters y=%h got=%0d lat=%0d want=%0d", y, if16.out_iters, c16, x / 16 + 1); end
         checks++; if (if16.out_err !== 1'b0) begin errors++; $display("FAIL sweep16_err y=%h got=%b want=0", y, if16.out_err); end
         if1.out_ready = 1'b1; if16.out_ready = 1'b1;
         tick();
         if1.out_ready = 1'b0; if16.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      send1(8'h48);
      repeat (40) tick();
      checks++; if (if1.busy !== 1'b1 || if1.out_valid !== 1'b0)
         begin errors++; $display("FAIL rstmid_pre got busy=%b vld=%b want 1/0", if1.busy, if1.out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (if1.busy !== 1'b0 || if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0)
         begin errors++; $display("FAIL rstmid_ctrl got busy=%b rdy=%b vld=%b want 0/1/0", if1.busy, if1.in_ready, if1.out_valid); end
      checks++; if (if1.out_data !== 8'h00 || if1.out_iters !== 9'd0 || if1.out_err !== 1'b0)
         begin errors++; $display("FAIL rstmid_data got data=%h iters=%0d err=%b want 00/0/0", if1.out_data, if1.out_iters, if1.out_err); end
      tick();
      rst_n = 1'b1;
      tick();
      send1(8'h90);
      wait1(cyc);
      checks++; if (if1.out_data !== 8'h01 || if1.out_iters !== 9'd2 || cyc !== 2)
         begin errors++; $display("FAIL rstmid_after got data=%h iters=%0d lat=%0d want 01/2/2", if1.out_data, if1.out_iters, cyc); end
      ack1();
   endtask

   task automatic test_ignore();
      int cyc;
      send1(8'hE9);
      if1.in_valid = 1'b1;
      if1.in_data  = 8'hD6;
      cyc = 0;
      while (if1.out_valid !== 1'b1 && cyc < 300) begin
         tick();
         if1.in_data = ~if1.in_data;
         cyc++;
      end
      if1.in_valid = 1'b0;
      checks++; if (if1.out_data !== 8'h02 || if1.out_iters !== 9'd3)
         begin errors++; $display("FAIL ignore_result got data=%h iters=%0d want 02/3", if1.out_data, if1.out_iters); end
      ack1();
      checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL ignore_ack_rdy got=%b want=1", if1.in_ready); end
      repeat (3) tick();
      checks++; if (if1.out_valid !== 1'b0 || if1.busy !== 1'b0)
         begin errors++; $display("FAIL ignore_no_queue got vld=%b busy=%b want 0/0", if1.out_valid, if1.busy); end
   endtask

   initial begin
      test_reset();
      test_first();
      test_max();
      test_hold();
      test_sweep();
      test_reset_mid();
      test_ignore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
